// File: rtl/cci_req_bridge_if.sv
// cci_req_bridge_if: groups every non-clock/reset signal of cci_req_bridge.
//   slave  modport : the bridge itself (takes user requests and CCI responses,
//                    drives TX requests, user responses, counts and status).
//   master modport : the environment (user block plus CCI channel model).
// Signal groups:
//   context   : ctx_load, src_base, dst_base
//   user read : rd_req_*, rd_rsp_*
//   user write: wr_req_*, wr_rsp0_*, wr_rsp1_*
//   CCI TX    : tx_c0_* (read), tx_c1_* (write)
//   CCI RX    : rx_c0_* (read/write responses), rx_c1_* (write responses)
//   status    : rd_outstanding, wr_outstanding, idle, err
interface cci_req_bridge_if #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = 64
) ();
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                   ctx_load;
    logic [31:0]            src_base;
    logic [31:0]            dst_base;

    logic                   rd_req_en;
    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_almostfull;
    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;

    logic                   wr_req_en;
    logic [ADDR_LMT-1:0]    wr_req_addr;
    logic [MDATA-1:0]       wr_req_mdata;
    logic [CACHE_WIDTH-1:0] wr_req_data;
    logic                   wr_req_almostfull;
    logic                   wr_rsp0_valid;
    logic [MDATA-1:0]       wr_rsp0_mdata;
    logic                   wr_rsp1_valid;
    logic [MDATA-1:0]       wr_rsp1_mdata;

    logic                   tx_c0_valid;
    logic [31:0]            tx_c0_addr;
    logic [MDATA-1:0]       tx_c0_mdata;
    logic                   tx_c0_almostfull;
    logic                   tx_c1_valid;
    logic [31:0]            tx_c1_addr;
    logic [MDATA-1:0]       tx_c1_mdata;
    logic [CACHE_WIDTH-1:0] tx_c1_data;
    logic                   tx_c1_almostfull;

    logic                   rx_c0_rdvalid;
    logic                   rx_c0_wrvalid;
    logic [MDATA-1:0]       rx_c0_mdata;
    logic [CACHE_WIDTH-1:0] rx_c0_data;
    logic                   rx_c1_wrvalid;
    logic [MDATA-1:0]       rx_c1_mdata;

    logic [CNT_W-1:0]       rd_outstanding;
    logic [CNT_W-1:0]       wr_outstanding;
    logic                   idle;
    logic                   err;

    modport slave (
        input  ctx_load, src_base, dst_base,
        input  rd_req_en, rd_req_addr, rd_req_mdata,
        output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        input  wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data,
        output wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        output tx_c0_valid, tx_c0_addr, tx_c0_mdata,
        input  tx_c0_almostfull,
        output tx_c1_valid, tx_c1_addr, tx_c1_mdata, tx_c1_data,
        input  tx_c1_almostfull,
        input  rx_c0_rdvalid, rx_c0_wrvalid, rx_c0_mdata, rx_c0_data,
        input  rx_c1_wrvalid, rx_c1_mdata,
        output rd_outstanding, wr_outstanding, idle, err
    );

    modport master (
        output ctx_load, src_base, dst_base,
        output rd_req_en, rd_req_addr, rd_req_mdata,
        input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        output wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data,
        input  wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        input  tx_c0_valid, tx_c0_addr, tx_c0_mdata,
        output tx_c0_almostfull,
        input  tx_c1_valid, tx_c1_addr, tx_c1_mdata, tx_c1_data,
        output tx_c1_almostfull,
        output rx_c0_rdvalid, rx_c0_wrvalid, rx_c0_mdata, rx_c0_data,
        output rx_c1_wrvalid, rx_c1_mdata,
        input  rd_outstanding, wr_outstanding, idle, err
    );
endinterface

// File: rtl/cci_req_bridge.sv
// cci_req_bridge: registers user read/write requests onto CCI TX channels 0/1,
// rebasing cache-line indices onto software-loaded source/destination bases,
// and registers CCI RX responses back to the user. Per-direction in-flight
// counters feed the advisory almost-full outputs; protocol violations set a
// sticky err flag.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus_if : cci_req_bridge_if.slave carrying all user, CCI and status signals
module cci_req_bridge #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic            clk,
    input  logic            reset,
    cci_req_bridge_if.slave bus_if
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(MAX_OUTSTANDING - 2);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             err;
    } cnt_upd_t;

    // Saturating in-flight update: clamp at 0 on underflow, hold at the limit
    // on overflow; either case is flagged.
    function automatic cnt_upd_t cnt_update(input logic [CNT_W-1:0] cnt,
                                            input logic             inc,
                                            input logic [1:0]       dec);
        cnt_upd_t r;
        int       n;
        n     = int'(cnt) + int'(inc) - int'(dec);
        r.cnt = cnt;
        r.err = 1'b0;
        if (n < 0) begin
            r.cnt = '0;
            r.err = 1'b1;
        end else if (n > MAX_OUTSTANDING) begin
            r.err = 1'b1;
        end else begin
            r.cnt = CNT_W'(n);
        end
        return r;
    endfunction

    logic [31:0]            src_base_q, dst_base_q;
    logic                   tx_c0_valid_q, tx_c1_valid_q;
    logic [31:0]            tx_c0_addr_q, tx_c1_addr_q;
    logic [MDATA-1:0]       tx_c0_mdata_q, tx_c1_mdata_q;
    logic [CACHE_WIDTH-1:0] tx_c1_data_q;
    logic                   rd_rsp_valid_q;
    logic [MDATA-1:0]       rd_rsp_mdata_q;
    logic [CACHE_WIDTH-1:0] rd_rsp_data_q;
    logic                   wr_rsp0_valid_q, wr_rsp1_valid_q;
    logic [MDATA-1:0]       wr_rsp0_mdata_q, wr_rsp1_mdata_q;
    logic [CNT_W-1:0]       rd_cnt_q, wr_cnt_q;
    logic                   err_q;

    cnt_upd_t   rd_upd, wr_upd;
    logic       idle;
    logic       c0_wr_fwd;
    logic       err_d;

    assign idle = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !tx_c0_valid_q && !tx_c1_valid_q;

    // A channel-0 write response that collides with a read response is dropped,
    // so it neither forwards nor returns write credit.
    assign c0_wr_fwd = bus_if.rx_c0_wrvalid && !bus_if.rx_c0_rdvalid;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_upd = cnt_update(rd_cnt_q, bus_if.rd_req_en, {1'b0, bus_if.rx_c0_rdvalid});
        wr_upd = cnt_update(wr_cnt_q, bus_if.wr_req_en,
                            {1'b0, c0_wr_fwd} + {1'b0, bus_if.rx_c1_wrvalid});
        err_d  = err_q | rd_upd.err | wr_upd.err
               | (bus_if.ctx_load && !idle)
               | (bus_if.rx_c0_rdvalid && bus_if.rx_c0_wrvalid);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide data registers are reset as well; their zero
            // reset value is a visible output, not just a don't-care.
            src_base_q      <= '0;
            dst_base_q      <= '0;
            tx_c0_valid_q   <= 1'b0;
            tx_c0_addr_q    <= '0;
            tx_c0_mdata_q   <= '0;
            tx_c1_valid_q   <= 1'b0;
            tx_c1_addr_q    <= '0;
            tx_c1_mdata_q   <= '0;
            tx_c1_data_q    <= '0;
            rd_rsp_valid_q  <= 1'b0;
            rd_rsp_mdata_q  <= '0;
            rd_rsp_data_q   <= '0;
            wr_rsp0_valid_q <= 1'b0;
            wr_rsp0_mdata_q <= '0;
            wr_rsp1_valid_q <= 1'b0;
            wr_rsp1_mdata_q <= '0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
            err_q           <= 1'b0;
        end else begin
            if (bus_if.ctx_load && idle) begin
                src_base_q <= bus_if.src_base;
                dst_base_q <= bus_if.dst_base;
            end

            tx_c0_valid_q <= bus_if.rd_req_en;
            if (bus_if.rd_req_en) begin
                tx_c0_addr_q  <= src_base_q + 32'(bus_if.rd_req_addr);
                tx_c0_mdata_q <= bus_if.rd_req_mdata;
            end

            tx_c1_valid_q <= bus_if.wr_req_en;
            if (bus_if.wr_req_en) begin
                tx_c1_addr_q  <= dst_base_q + 32'(bus_if.wr_req_addr);
                tx_c1_mdata_q <= bus_if.wr_req_mdata;
                tx_c1_data_q  <= bus_if.wr_req_data;
            end

            rd_rsp_valid_q <= bus_if.rx_c0_rdvalid;
            if (bus_if.rx_c0_rdvalid) begin
                rd_rsp_mdata_q <= bus_if.rx_c0_mdata;
                rd_rsp_data_q  <= bus_if.rx_c0_data;
            end

            wr_rsp0_valid_q <= c0_wr_fwd;
            if (c0_wr_fwd) wr_rsp0_mdata_q <= bus_if.rx_c0_mdata;

            wr_rsp1_valid_q <= bus_if.rx_c1_wrvalid;
            if (bus_if.rx_c1_wrvalid) wr_rsp1_mdata_q <= bus_if.rx_c1_mdata;

            rd_cnt_q <= rd_upd.cnt;
            wr_cnt_q <= wr_upd.cnt;
            err_q    <= err_d;
        end
    end

    assign bus_if.tx_c0_valid       = tx_c0_valid_q;
    assign bus_if.tx_c0_addr        = tx_c0_addr_q;
    assign bus_if.tx_c0_mdata       = tx_c0_mdata_q;
    assign bus_if.tx_c1_valid       = tx_c1_valid_q;
    assign bus_if.tx_c1_addr        = tx_c1_addr_q;
    assign bus_if.tx_c1_mdata       = tx_c1_mdata_q;
    assign bus_if.tx_c1_data        = tx_c1_data_q;
    assign bus_if.rd_rsp_valid      = rd_rsp_valid_q;
    assign bus_if.rd_rsp_mdata      = rd_rsp_mdata_q;
    assign bus_if.rd_rsp_data       = rd_rsp_data_q;
    assign bus_if.wr_rsp0_valid     = wr_rsp0_valid_q;
    assign bus_if.wr_rsp0_mdata     = wr_rsp0_mdata_q;
    assign bus_if.wr_rsp1_valid     = wr_rsp1_valid_q;
    assign bus_if.wr_rsp1_mdata     = wr_rsp1_mdata_q;
    assign bus_if.rd_outstanding    = rd_cnt_q;
    assign bus_if.wr_outstanding    = wr_cnt_q;
    assign bus_if.idle              = idle;
    assign bus_if.err               = err_q;

    // The two-entry margin absorbs the user's one-cycle registered enable lag.
    assign bus_if.rd_req_almostfull = bus_if.tx_c0_almostfull | (rd_cnt_q >= AF_LEVEL);
    assign bus_if.wr_req_almostfull = bus_if.tx_c1_almostfull | (wr_cnt_q >= AF_LEVEL);
endmodule

// File: tb/tb_cci_req_bridge.sv
// tb_cci_req_bridge: directed stimulus for cci_req_bridge, checked every
// cycle against a transaction-level model plus hand-computed literals.
module tb_cci_req_bridge;
    localparam int ADDR_LMT = 20;
    localparam int MDATA    = 14;
    localparam int CW       = 512;
    localparam int MAXO     = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cci_req_bridge_if #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW),
                        .MAX_OUTSTANDING(MAXO)) bus_if ();

    cci_req_bridge #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW),
                     .MAX_OUTSTANDING(MAXO)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit               model_ok = 0;
    logic [31:0]      m_src, m_dst;
    int               m_rd, m_wr;
    bit               m_err;
    bit               e_c0_v, e_c1_v, e_rrsp_v, e_w0_v, e_w1_v;
    logic [31:0]      e_c0_addr, e_c1_addr;
    logic [MDATA-1:0] e_c0_md, e_c1_md, e_rrsp_md, e_w0_md, e_w1_md;
    logic [CW-1:0]    e_c1_data, e_rrsp_data;

    function automatic int clamp_cnt(input int n, inout bit e);
        if (n < 0) begin e = 1; return 0; end
        if (n > MAXO) begin e = 1; return MAXO; end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1;
            m_src = 0; m_dst = 0; m_rd = 0; m_wr = 0; m_err = 0;
            e_c0_v = 0; e_c1_v = 0; e_rrsp_v = 0; e_w0_v = 0; e_w1_v = 0;
        end else begin
            bit was_idle, both;
            int wr_dec;
            was_idle = (m_rd == 0) && (m_wr == 0) && !e_c0_v && !e_c1_v;
            both     = bus_if.rx_c0_rdvalid && bus_if.rx_c0_wrvalid;
            // requests use the bases in force before any load this cycle
            e_c0_v = bus_if.rd_req_en;
            e_c0_addr = m_src + {12'b0, bus_if.rd_req_addr};
            e_c0_md = bus_if.rd_req_mdata;
            e_c1_v = bus_if.wr_req_en;
            e_c1_addr = m_dst + {12'b0, bus_if.wr_req_addr};
            e_c1_md = bus_if.wr_req_mdata;
            e_c1_data = bus_if.wr_req_data;
            if (bus_if.ctx_load) begin
                if (was_idle) begin m_src = bus_if.src_base; m_dst = bus_if.dst_base; end
                else m_err = 1;
            end
            if (both) m_err = 1;
            e_rrsp_v = bus_if.rx_c0_rdvalid;
            e_rrsp_md = bus_if.rx_c0_mdata;
            e_rrsp_data = bus_if.rx_c0_data;
            e_w0_v = bus_if.rx_c0_wrvalid && !both;
            e_w0_md = bus_if.rx_c0_mdata;
            e_w1_v = bus_if.rx_c1_wrvalid;
            e_w1_md = bus_if.rx_c1_mdata;
            wr_dec = int'(e_w0_v) + int'(e_w1_v);
            m_rd = clamp_cnt(m_rd + int'(bus_if.rd_req_en) - int'(bus_if.rx_c0_rdvalid), m_err);
            m_wr = clamp_cnt(m_wr + int'(bus_if.wr_req_en) - wr_dec, m_err);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("tx_c0_valid", bus_if.tx_c0_valid, e_c0_v);
            if (e_c0_v) begin
                check("tx_c0_addr", bus_if.tx_c0_addr, e_c0_addr);
                check("tx_c0_mdata", bus_if.tx_c0_mdata, e_c0_md);
            end
            check("tx_c1_valid", bus_if.tx_c1_valid, e_c1_v);
            if (e_c1_v) begin
                check("tx_c1_addr", bus_if.tx_c1_addr, e_c1_addr);
                check("tx_c1_mdata", bus_if.tx_c1_mdata, e_c1_md);
                check("tx_c1_data", bus_if.tx_c1_data, e_c1_data);
            end
            check("rd_rsp_valid", bus_if.rd_rsp_valid, e_rrsp_v);
            if (e_rrsp_v) begin
                check("rd_rsp_mdata", bus_if.rd_rsp_mdata, e_rrsp_md);
                check("rd_rsp_data", bus_if.rd_rsp_data, e_rrsp_data);
            end
            check("wr_rsp0_valid", bus_if.wr_rsp0_valid, e_w0_v);
            if (e_w0_v) check("wr_rsp0_mdata", bus_if.wr_rsp0_mdata, e_w0_md);
            check("wr_rsp1_valid", bus_if.wr_rsp1_valid, e_w1_v);
            if (e_w1_v) check("wr_rsp1_mdata", bus_if.wr_rsp1_mdata, e_w1_md);
            check("rd_outstanding", bus_if.rd_outstanding, m_rd);
            check("wr_outstanding", bus_if.wr_outstanding, m_wr);
            check("idle", bus_if.idle, (m_rd == 0) && (m_wr == 0) && !e_c0_v && !e_c1_v);
            check("err", bus_if.err, m_err);
            check("rd_req_almostfull", bus_if.rd_req_almostfull,
                  bus_if.tx_c0_almostfull || (m_rd >= MAXO - 2));
            check("wr_req_almostfull", bus_if.wr_req_almostfull,
                  bus_if.tx_c1_almostfull || (m_wr >= MAXO - 2));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.ctx_load = 0;
        bus_if.rd_req_en = 0;
        bus_if.wr_req_en = 0;
        bus_if.rx_c0_rdvalid = 0;
        bus_if.rx_c0_wrvalid = 0;
        bus_if.rx_c1_wrvalid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic rd(input int a, input int md);
        bus_if.rd_req_en = 1;
        bus_if.rd_req_addr = ADDR_LMT'(a);
        bus_if.rd_req_mdata = MDATA'(md);
    endtask

    task automatic wr(input int a, input int md);
        bus_if.wr_req_en = 1;
        bus_if.wr_req_addr = ADDR_LMT'(a);
        bus_if.wr_req_mdata = MDATA'(md);
        bus_if.wr_req_data = {16{32'hA5A5_0000 ^ 32'(a)}};
    endtask

    task automatic ctx(input logic [31:0] s, input logic [31:0] d);
        bus_if.ctx_load = 1;
        bus_if.src_base = s;
        bus_if.dst_base = d;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_c0_valid"}, bus_if.tx_c0_valid, 0);
        check({tag, "_tx_c1_valid"}, bus_if.tx_c1_valid, 0);
        check({tag, "_tx_c0_addr"}, bus_if.tx_c0_addr, 0);
        check({tag, "_tx_c1_addr"}, bus_if.tx_c1_addr, 0);
        check({tag, "_tx_c1_data"}, bus_if.tx_c1_data, 0);
        check({tag, "_rd_rsp_valid"}, bus_if.rd_rsp_valid, 0);
        check({tag, "_rd_rsp_mdata"}, bus_if.rd_rsp_mdata, 0);
        check({tag, "_counts"}, {bus_if.rd_outstanding, bus_if.wr_outstanding}, 0);
        check({tag, "_idle"}, bus_if.idle, 1);
        check({tag, "_err"}, bus_if.err, 0);
        check({tag, "_model_rd"}, m_rd, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.ctx_load = 0; bus_if.src_base = 0; bus_if.dst_base = 0;
        bus_if.rd_req_en = 0; bus_if.rd_req_addr = 0; bus_if.rd_req_mdata = 0;
        bus_if.wr_req_en = 0; bus_if.wr_req_addr = 0; bus_if.wr_req_mdata = 0;
        bus_if.wr_req_data = 0;
        bus_if.tx_c0_almostfull = 0; bus_if.tx_c1_almostfull = 0;
        bus_if.rx_c0_rdvalid = 0; bus_if.rx_c0_wrvalid = 0; bus_if.rx_c0_mdata = 0;
        bus_if.rx_c0_data = 0; bus_if.rx_c1_wrvalid = 0; bus_if.rx_c1_mdata = 0;

        do_reset();
        check_reset_values("rst0");

        // basic rebase on both channels
        ctx(32'h1000, 32'h8000); tick();
        rd(5, 'h11); wr(7, 'h22); tick();
        check("lit_c0_addr", bus_if.tx_c0_addr, 32'h1005);
        check("lit_c1_addr", bus_if.tx_c1_addr, 32'h8007);
        check("lit_rd_cnt", bus_if.rd_outstanding, 1);
        check("lit_wr_cnt", bus_if.wr_outstanding, 1);
        check("lit_model_wr", m_wr, 1);
        check("lit_busy", bus_if.idle, 0);
        bus_if.rx_c0_rdvalid = 1; bus_if.rx_c0_mdata = 'h11;
        bus_if.rx_c0_data = {8{64'h0123_4567_89AB_CDEF}};
        bus_if.rx_c1_wrvalid = 1; bus_if.rx_c1_mdata = 'h22;
        tick();
        check("lit_rd_rsp_mdata", bus_if.rd_rsp_mdata, 'h11);
        check("lit_rd_rsp_data", bus_if.rd_rsp_data, {8{64'h0123_4567_89AB_CDEF}});
        check("lit_wr_rsp1", {bus_if.wr_rsp1_valid, bus_if.wr_rsp1_mdata}, {1'b1, 14'h22});
        check("lit_idle_again", bus_if.idle, 1);

        // address wrap modulo 2^32
        ctx(32'hFFFF_FFFE, 32'h0); tick();
        rd(3, 'h3); tick();
        check("lit_wrap_addr", bus_if.tx_c0_addr, 32'h0000_0001);
        bus_if.rx_c0_rdvalid = 1; bus_if.rx_c0_mdata = 'h3; tick();

        // stream reads up to and past the in-flight limit
        for (int i = 1; i <= 62; i++) begin
            rd(i, i); tick();
            if (i == 61) check("lit_af_at_61", bus_if.rd_req_almostfull, 0);
        end
        check("lit_af_at_62", bus_if.rd_req_almostfull, 1);
        check("lit_cnt_62", bus_if.rd_outstanding, 62);
        rd(63, 63); tick();
        rd(64, 64); tick();
        check("lit_cnt_64", bus_if.rd_outstanding, 64);
        check("lit_err_at_64", bus_if.err, 0);
        rd(65, 65); tick();
        check("lit_err_overflow", bus_if.err, 1);
        check("lit_cnt_hold", bus_if.rd_outstanding, 64);
        check("lit_65th_issued", bus_if.tx_c0_valid, 1);

        // reset discards counts and err
        do_reset();
        check_reset_values("rst1");

        // write almost-full follows the TX FIFO flag
        bus_if.tx_c1_almostfull = 1; #1;
        check("lit_wr_af_tx", bus_if.wr_req_almostfull, 1);
        check("lit_rd_af_clear", bus_if.rd_req_almostfull, 0);
        bus_if.tx_c1_almostfull = 0;

        // write issued while two write responses retire
        ctx(32'h0, 32'h100); tick();
        for (int i = 0; i < 3; i++) begin wr(i, 'h30 + i); tick(); end
        check("lit_wr_cnt3", bus_if.wr_outstanding, 3);
        wr(9, 'h39);
        bus_if.rx_c0_wrvalid = 1; bus_if.rx_c0_mdata = 'h31;
        bus_if.rx_c1_wrvalid = 1; bus_if.rx_c1_mdata = 'h32;
        tick();
        check("lit_wr_cnt2", bus_if.wr_outstanding, 2);
        check("lit_wr_rsp0", {bus_if.wr_rsp0_valid, bus_if.wr_rsp0_mdata}, {1'b1, 14'h31});
        check("lit_wr_rsp1b", {bus_if.wr_rsp1_valid, bus_if.wr_rsp1_mdata}, {1'b1, 14'h32});
        check("lit_wr_c1_addr", bus_if.tx_c1_addr, 32'h109);
        check("lit_err_clean", bus_if.err, 0);

        // read response underflow
        do_reset();
        bus_if.rx_c0_rdvalid = 1; bus_if.rx_c0_mdata = 'h2A; tick();
        check("lit_uf_valid", bus_if.rd_rsp_valid, 1);
        check("lit_uf_mdata", bus_if.rd_rsp_mdata, 'h2A);
        check("lit_uf_err", bus_if.err, 1);
        check("lit_uf_cnt", bus_if.rd_outstanding, 0);

        // context load while busy is ignored
        do_reset();
        ctx(32'h2000, 32'h3000); tick();
        rd(1, 1); tick();
        check("lit_busy_cnt", bus_if.rd_outstanding, 1);
        ctx(32'hABC0, 32'hDEF0); tick();
        check("lit_ctx_err", bus_if.err, 1);
        rd(0, 2); tick();
        check("lit_base_kept", bus_if.tx_c0_addr, 32'h2000);

        // colliding channel-0 read and write responses
        do_reset();
        rd(0, 4); wr(0, 5); tick();
        bus_if.rx_c0_rdvalid = 1; bus_if.rx_c0_wrvalid = 1; bus_if.rx_c0_mdata = 'h4; tick();
        check("lit_coll_rd", bus_if.rd_rsp_valid, 1);
        check("lit_coll_wr_drop", bus_if.wr_rsp0_valid, 0);
        check("lit_coll_err", bus_if.err, 1);
        check("lit_coll_rd_cnt", bus_if.rd_outstanding, 0);

        // reset mid-operation, then a late response
        rd(2, 6); tick();
        do_reset();
        check_reset_values("rst_final");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cci_req_bridge.md
# cci_req_bridge

Request/response bridge between the bandwidth-benchmark user block and the CCI channel interface. Rebases user cache-line indices onto software-supplied source/destination addresses, registers requests onto CCI TX channels 0 (read) and 1 (write), and routes RX responses back to the user. It also tracks outstanding reads and writes so the user's almost-full inputs account for in-flight credit, not only TX FIFO fill.

## Interface
- ADDR_LMT, 20, width of user cache-line index
- MDATA, 14, metadata tag width
- CACHE_WIDTH, 512, cache-line data width
- MAX_OUTSTANDING, 64, per-direction in-flight limit (≥4)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ctx_load  in  1  one-cycle pulse that latches src_base/dst_base
- src_base, dst_base  in  32  cache-line base addresses
- rd_req_en / rd_req_addr / rd_req_mdata  in  1/ADDR_LMT/MDATA  user read request
- rd_req_almostfull  out  1  user read back-pressure
- rd_rsp_valid / rd_rsp_mdata / rd_rsp_data  out  1/MDATA/CACHE_WIDTH  user read response
- wr_req_en / wr_req_addr / wr_req_mdata / wr_req_data  in  1/ADDR_LMT/MDATA/CACHE_WIDTH  user write request
- wr_req_almostfull  out  1  user write back-pressure
- wr_rsp0_valid / wr_rsp0_mdata, wr_rsp1_valid / wr_rsp1_mdata  out  1/MDATA each  user write responses
- tx_c0_valid / tx_c0_addr / tx_c0_mdata  out  1/32/MDATA  CCI read request
- tx_c0_almostfull  in  1  CCI read request FIFO nearly full
- tx_c1_valid / tx_c1_addr / tx_c1_mdata / tx_c1_data  out  1/32/MDATA/CACHE_WIDTH  CCI write request
- tx_c1_almostfull  in  1  CCI write request FIFO nearly full
- rx_c0_rdvalid, rx_c0_wrvalid / rx_c0_mdata / rx_c0_data  in  1,1/MDATA/CACHE_WIDTH  CCI channel-0 response
- rx_c1_wrvalid / rx_c1_mdata  in  1/MDATA  CCI channel-1 write response
- rd_outstanding, wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight counts
- idle  out  1  both counts zero and no TX valid pending
- err  out  1  sticky protocol-error flag

## Operation
- Bases: ctx_load with idle=1 latches src_base/dst_base. ctx_load with idle=0 is ignored and sets err.
- Read path: rd_req_en registers tx_c0_valid=1, tx_c0_addr=src_base+zero-extended rd_req_addr (mod 2^32), and tx_c0_mdata=rd_req_mdata. The write path is identical on channel 1 using dst_base and forwards data unchanged.
- Requests are always accepted. Back-pressure is advisory only:
  - rd_req_almostfull = tx_c0_almostfull | (rd_outstanding ≥ MAX_OUTSTANDING−2).
  - wr_req_almostfull is the same, using channel 1 and wr_outstanding.
  - The margin of 2 covers the user's one-cycle registered enable lag.
- Responses, each registered one cycle:
  - rx_c0_rdvalid → rd_rsp_valid, with mdata/data copied.
  - rx_c0_wrvalid → wr_rsp0_valid.
  - rx_c1_wrvalid → wr_rsp1_valid.
- rd_outstanding: +1 when a read is issued on TX, −1 on rx_c0_rdvalid. Issue and response in the same cycle leave it unchanged.
- wr_outstanding: +1 when a write is issued on TX, −(rx_c0_wrvalid+rx_c1_wrvalid). The net change per cycle is in {+1, 0, −1, −2}.
- Underflow: a response that would drive a count below 0 clamps the count at 0, sets err, and is still forwarded.
- Overflow: a request accepted at count=MAX_OUTSTANDING holds the count, sets err, and is still issued.
- Simultaneous rx_c0_rdvalid and rx_c0_wrvalid sets err. The read response is forwarded and the write is dropped.

## Timing
- Latency is 1 cycle request→TX and 1 cycle RX→user response. There are no bubbles; one request per channel is issued per cycle.
- Counters update on the cycle the TX valid asserts, i.e. one cycle after the user enable.
- almostfull outputs are combinational from tx_*_almostfull and registered counts.
- err clears only on reset.
- Reset values: all *_valid=0, addr/mdata/data outputs=0, counts=0, bases=0, err=0, idle=1, almostfull outputs follow tx_*_almostfull.
- Reset mid-operation:
  - Counts are discarded.
  - Responses arriving after reset for pre-reset requests are forwarded and set err (underflow).
  - Software must drain before reset.

## Test plan
- ctx_load src_base=0x1000, dst_base=0x8000; read addr 5, write addr 7 → next cycle tx_c0_addr=0x1005, tx_c1_addr=0x8007, both counts=1.
- src_base=0xFFFF_FFFE, read addr 3 → tx_c0_addr=0x0000_0001 (wrap).
- Stream 62 reads with no responses → rd_req_almostfull=1 once rd_outstanding=62. Two further reads → count=64, err=0. A 65th read → err=1, count stays 64.
- Same cycle: write issued, rx_c0_wrvalid=1 and rx_c1_wrvalid=1 with wr_outstanding=3 → wr_outstanding=2, wr_rsp0_valid=wr_rsp1_valid=1 next cycle with matching mdata.
- rx_c0_rdvalid with rd_outstanding=0, mdata=0x2A → rd_rsp_valid=1, mdata=0x2A, err=1, count stays 0.
- ctx_load while rd_outstanding=1 → bases unchanged, err=1. After a reset pulse → all outputs at reset values, idle=1.
